mult_shift_add: RTL and testbench
=================================

Name: mult_shift_add

Overview:
- Iterative shift-and-add multiplier. Consumes the ripple-carry adder chain built from HALF_ADDER/FULL_ADDER cells, one add per cycle.
- Sits downstream of the adder stage and feeds the ALU MUL result path (HI/LO).
- Start/done handshake; result registered and held until the next operation.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
- CLK    input   1      system clock, rising edge
- RST    input   1      synchronous, active-high reset
- START  input   1      request new multiply; sampled only in IDLE
- A      input   WIDTH  multiplicand, sampled with START
- B      input   WIDTH  multiplier, sampled with START
- BUSY   output  1      high whenever state != IDLE
- DONE   output  1      one-cycle pulse: HI/LO just updated
- HI     output  WIDTH  upper half of product
- LO     output  WIDTH  lower half of product

Behaviour:
- One clock (CLK). Reset RST is synchronous and active-high: at a rising edge with RST=1 → state IDLE, BUSY=0, DONE=0, HI=0, LO=0, internal regs 0. RST has priority over all other inputs.
- States:
  - IDLE: START=1 → latch MCAND=A; P={ (WIDTH+1)'b0, B }; CNT=0; go RUN. START=0 → stay.
  - RUN: per edge, if P[0]=1 then P[2W:W] = P[2W-1:W] + MCAND, carry into P[2W]. Then P shifts right 1; CNT++.
    - When CNT reaches WIDTH-1 (iteration WIDTH done) → HI=P[2W-1:W], LO=P[W-1:0] (post-shift), go FIN.
  - FIN: DONE=1 for this cycle only; next edge → IDLE.
- Latency: START sampled at edge k; iterations at edges k+1..k+WIDTH; DONE high in the cycle after edge k+WIDTH (33 cycles after START for WIDTH=32); BUSY low again after edge k+WIDTH+1.
- START while BUSY (RUN or FIN) is ignored; operands are not re-sampled.
- A/B may change freely after the START edge.
- HI/LO change only on the completion edge; they hold through IDLE and the following RUN.
- Adder: WIDTH-bit add with carry-out, no overflow loss. Product is exact mod 2^(2W).
- Reset mid-RUN → IDLE immediately. No DONE pulse; HI/LO=0.
- MUL by 0 or 1 still takes the full WIDTH iterations; no early exit.

Optional Feature:
- Macro: MULT_SIGNED_EN
- Defined: A, B are two's complement.
  - At START, latch |A| and |B| plus SIGN = A[W-1]^B[W-1].
  - At completion, if SIGN=1, {HI,LO} = two's complement of the magnitude product.
  - Most-negative operand (0x80000000): magnitude 2^31 fits unsigned WIDTH; the result must be correct.
  - Latency unchanged.
- Undefined: unsigned multiply only; no sign logic synthesized.

Decomposition:
- Shared definitions include (prj_definition.v) carries:
  - the data width constant (data index limit / width 32) used as the WIDTH default;
  - state encodings MULT_IDLE=2'b00, MULT_RUN=2'b01, MULT_FIN=2'b10;
  - iteration-count width (5+1 bits).
- One sub-module: rc_add_w, a WIDTH-bit ripple-carry adder with carry-out, built from the existing FULL_ADDER/HALF_ADDER cells.
  - The multiplier instantiates it once for the accumulate step.
  - With MULT_SIGNED_EN, negation reuses the same adder structure (invert + 1) in a second instance.

Test Plan:
- Reset, then A=3, B=5, START 1 cycle → DONE pulse exactly 33 cycles later, HI=0x00000000, LO=0x0000000F, BUSY=0 next cycle.
- A=0xFFFFFFFF, B=0xFFFFFFFF (unsigned build) → HI=0xFFFFFFFE, LO=0x00000001.
- A=0xFFFFFFFD, B=5:
  - unsigned build → HI=0x00000004, LO=0xFFFFFFF1;
  - MULT_SIGNED_EN build → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULT_SIGNED_EN, A=B=0x80000000 → HI=0x40000000, LO=0x00000000.
- START held high continuously with A/B changing every cycle → only the operands from the first edge are used. The next op starts on the first IDLE cycle. HI/LO hold between DONE pulses.
- RST=1 at the 10th RUN cycle → next cycle BUSY=0, HI=LO=0, no DONE. A new START then completes normally (7*9 → LO=0x3F).

Source files
------------

// File: rtl/mult_shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier: default data width and
// FSM state encodings.
package mult_shift_add_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'b00,
    MULT_RUN  = 2'b01,
    MULT_FIN  = 2'b10
  } mult_state_t;

endpackage

// File: rtl/mult_shift_add_if.sv
// Start/done handshake and HI/LO result bus between a requester (master) and
// the multiplier (slave).
interface mult_shift_add_if
  import mult_shift_add_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output START, A, B, input BUSY, DONE, HI, LO);
  modport slave  (input START, A, B, output BUSY, DONE, HI, LO);
endinterface

// File: rtl/mult_shift_add_rc_add_w.sv
// WIDTH-bit ripple-carry adder with carry-in and carry-out, one full-adder
// cell per bit.
module mult_shift_add_rc_add_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];
endmodule

// File: rtl/mult_shift_add.sv
// Iterative shift-and-add multiplier: one accumulate per clock, WIDTH clocks
// per product. Define MULT_SIGNED_EN for two's-complement operands.
module mult_shift_add
  import mult_shift_add_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input logic            CLK,
  input logic            RST,
  mult_shift_add_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  mult_state_t        state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] p;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   acc_sum;
  logic               acc_co;
  logic [2*WIDTH-1:0] p_shift;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_final;

  assign add_b = p[0] ? mcand : '0;

  mult_shift_add_rc_add_w #(.WIDTH(WIDTH)) u_acc (
    .a    (p[2*WIDTH-1:WIDTH]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (acc_sum),
    .cout (acc_co)
  );

  // The carry-out lands directly in the top bit after the shift, so the
  // extra (2W)th product bit never needs to be stored.
  assign p_shift = {acc_co, acc_sum, p[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
  logic               sign_q;
  logic [WIDTH-1:0]   neg_a;
  logic [WIDTH-1:0]   neg_b;
  logic [2*WIDTH-1:0] neg_p;
  logic               neg_a_co;
  logic               neg_b_co;
  logic               neg_p_co;
  logic               unused_carries;

  mult_shift_add_rc_add_w #(.WIDTH(WIDTH)) u_neg_a (
    .a(~bus.A), .b('0), .cin(1'b1), .sum(neg_a), .cout(neg_a_co)
  );
  mult_shift_add_rc_add_w #(.WIDTH(WIDTH)) u_neg_b (
    .a(~bus.B), .b('0), .cin(1'b1), .sum(neg_b), .cout(neg_b_co)
  );
  mult_shift_add_rc_add_w #(.WIDTH(2*WIDTH)) u_neg_p (
    .a(~p_shift), .b('0), .cin(1'b1), .sum(neg_p), .cout(neg_p_co)
  );

  // The most-negative operand negates to itself, which is its correct
  // unsigned magnitude.
  assign mag_a          = bus.A[WIDTH-1] ? neg_a : bus.A;
  assign mag_b          = bus.B[WIDTH-1] ? neg_b : bus.B;
  assign prod_final     = sign_q ? neg_p : p_shift;
  assign unused_carries = &{1'b0, neg_a_co, neg_b_co, neg_p_co};
`else
  assign mag_a      = bus.A;
  assign mag_b      = bus.B;
  assign prod_final = p_shift;
`endif

  // NOTE: every register here, state and datapath alike, is cleared by the
  // synchronous reset so a reset mid-run leaves no stale partial product.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= MULT_IDLE;
      mcand  <= '0;
      p      <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef MULT_SIGNED_EN
      sign_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every branch reads the values
      // from before this edge regardless of statement order.
      case (state)
        MULT_IDLE: begin
          if (bus.START) begin
            mcand  <= mag_a;
            p      <= {{WIDTH{1'b0}}, mag_b};
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= MULT_RUN;
`ifdef MULT_SIGNED_EN
            sign_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
`endif
          end
        end
        MULT_RUN: begin
          p   <= p_shift;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            hi_q   <= prod_final[2*WIDTH-1:WIDTH];
            lo_q   <= prod_final[WIDTH-1:0];
            done_q <= 1'b1;
            state  <= MULT_FIN;
          end
        end
        MULT_FIN: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= MULT_IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= MULT_IDLE;
        end
      endcase
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mult_shift_add.sv
// Directed self-checking bench for mult_shift_add; expected products are
// hand-computed for both the unsigned and the MULT_SIGNED_EN build.
module tb_mult_shift_add;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic CLK = 1'b0;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  mult_shift_add_if #(.WIDTH(W)) bus ();

  mult_shift_add #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called one edge after the START edge; scrambles A/B every cycle, checks
  // HI/LO hold their previous value until DONE, and counts edges from the
  // START edge inclusive to the DONE cycle.
  task automatic wait_done(input string tag, input logic [63:0] hold, output int edges);
    logic held_ok;
    held_ok = 1'b1;
    edges   = 1;
    while (bus.DONE !== 1'b1 && edges < 100) begin
      if ({bus.HI, bus.LO} !== hold) held_ok = 1'b0;
      bus.A = $urandom;
      bus.B = $urandom;
      step();
      edges++;
    end
    check({tag, " hold"}, {63'd0, held_ok}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    logic [63:0] prev;
    int          edges;
    prev      = {bus.HI, bus.LO};
    bus.A     = a;
    bus.B     = b;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    check({tag, " busy"}, {63'd0, bus.BUSY}, 64'd1);
    wait_done(tag, prev, edges);
    check({tag, " latency"}, 64'(edges), 64'(LAT));
    check({tag, " product"}, {bus.HI, bus.LO}, exp);
    step();
    check({tag, " done_pulse"}, {63'd0, bus.DONE}, 64'd0);
    check({tag, " idle"}, {63'd0, bus.BUSY}, 64'd0);
    check({tag, " result_held"}, {bus.HI, bus.LO}, exp);
  endtask

  initial begin
    logic [63:0] prev;
    logic        seen_done;
    int          edges;

    RST       = 1'b1;
    bus.START = 1'b0;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'hCAFE_F00D;
    step();
    step();
    check("reset busy", {63'd0, bus.BUSY}, 64'd0);
    check("reset done", {63'd0, bus.DONE}, 64'd0);
    check("reset hi",   {32'd0, bus.HI}, 64'd0);
    check("reset lo",   {32'd0, bus.LO}, 64'd0);
    RST = 1'b0;
    step();

    run_op("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
`ifdef MULT_SIGNED_EN
    run_op("m1xm1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_op("m3x5",    32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1);
    run_op("min2",    32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("7xmin",   32'd7,         32'h8000_0000, 64'hFFFF_FFFC_8000_0000);
`else
    run_op("max2",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("fffdx5",  32'hFFFF_FFFD, 32'd5,         64'h0000_0004_FFFF_FFF1);
    run_op("min2",    32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("7xmin",   32'd7,         32'h8000_0000, 64'h0000_0003_8000_0000);
`endif
    run_op("x1", 32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678);
    run_op("x0", 32'hDEAD_BEEF, 32'd0, 64'h0000_0000_0000_0000);

    // START held high with operands scrambling every cycle.
    prev      = {bus.HI, bus.LO};
    bus.A     = 32'd10;
    bus.B     = 32'd20;
    bus.START = 1'b1;
    step();
    wait_done("held1", prev, edges);
    check("held1 latency", 64'(edges), 64'(LAT));
    check("held1 product", {bus.HI, bus.LO}, 64'd200);
    bus.A = 32'd6;
    bus.B = 32'd7;
    step();
    check("held fin_to_idle", {63'd0, bus.BUSY}, 64'd0);
    check("held idle hold", {bus.HI, bus.LO}, 64'd200);
    step();
    check("held restart busy", {63'd0, bus.BUSY}, 64'd1);
    bus.START = 1'b0;
    wait_done("held2", 64'd200, edges);
    check("held2 latency", 64'(edges), 64'(LAT));
    check("held2 product", {bus.HI, bus.LO}, 64'd42);
    step();

    // Reset in the middle of a run.
    bus.A     = 32'h1111_1111;
    bus.B     = 32'd3;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("midrun busy", {63'd0, bus.BUSY}, 64'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst busy", {63'd0, bus.BUSY}, 64'd0);
    check("rst hilo", {bus.HI, bus.LO}, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.DONE !== 1'b0) seen_done = 1'b1;
      step();
    end
    check("rst no_done", {63'd0, seen_done}, 64'd0);
    run_op("7x9", 32'd7, 32'd9, 64'h0000_0000_0000_003F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
